// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus: decode-side inputs toward the controller, fetch/status outputs back.
// slave = ifu_fetch_ctrl, master = the decode/upstream side.
interface ifu_fetch_ctrl_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] address26;
    logic [31:0] jr_target;
    logic [31:0] addr_im;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fetch_valid;
    logic        halt;
    logic [31:0] fault_pc;
    logic [31:0] instr_count;

    modport master (
        output stall, npc_sel, branch_taken, imm16, address26, jr_target,
        input  addr_im, pc, pc_plus8, fetch_valid, halt, fault_pc, instr_count
    );

    modport slave (
        input  stall, npc_sel, branch_taken, imm16, address26, jr_target,
        output addr_im, pc, pc_plus8, fetch_valid, halt, fault_pc, instr_count
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, selects next PC, traps bad targets into HALT.
// Optional retired-fetch counter enabled by defining FETCH_CNT_EN.
module ifu_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic           clk,
    input  logic           reset,
    ifu_fetch_ctrl_if.slave fif
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] IM_LIMIT = PC_RESET + (XLEN'(IM_DEPTH) << 2);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_r, pc_nxt;
    logic [XLEN-1:0] fault_pc_r, fault_pc_nxt;
    logic [XLEN-1:0] seq_pc, br_off, target;
    logic            fault;

    // Candidate next PC and its range/alignment check
    always_comb begin
        seq_pc = pc_r + XLEN'(4);
        br_off = {{14{fif.imm16[15]}}, fif.imm16, 2'b00};
        unique case (fif.npc_sel)
            2'd0:    target = seq_pc;
            2'd1:    target = fif.branch_taken ? (seq_pc + br_off) : seq_pc;
            2'd2:    target = {pc_r[31:28], fif.address26, 2'b00};
            default: target = fif.jr_target;
        endcase
        fault = (target[1:0] != 2'b00) || (target < PC_RESET) || (target >= IM_LIMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc_r       <= PC_RESET;
            fault_pc_r <= '0;
        end else begin
            state      <= state_nxt;
            pc_r       <= pc_nxt;
            fault_pc_r <= fault_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_r;
        fault_pc_nxt = fault_pc_r;
        unique case (state)
            BOOT: begin
                if (!fif.stall) state_nxt = RUN;
            end
            RUN: begin
                if (!fif.stall) begin
                    if (fault) begin
                        fault_pc_nxt = target;
                        state_nxt    = HALT;
                    end else begin
                        pc_nxt = target;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign fif.addr_im     = pc_r;
    assign fif.pc          = pc_r;
    assign fif.pc_plus8    = pc_r + XLEN'(8);
    assign fif.fetch_valid = (state == RUN);
    assign fif.halt        = (state == HALT);
    assign fif.fault_pc    = fault_pc_r;

`ifdef FETCH_CNT_EN
    logic            cnt_inc;
    logic [XLEN-1:0] cnt_r;

    assign cnt_inc = (state == RUN) && !fif.stall && !fault;

    // Retired-fetch counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_r <= '0;
        else if (cnt_inc) cnt_r <= cnt_r + XLEN'(1);
    end

    assign fif.instr_count = cnt_r;
`else
    assign fif.instr_count = '0;
`endif
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: sequential, branch, jump, stall, fault and async reset.
module tb_ifu_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    ifu_fetch_ctrl_if fif ();

    ifu_fetch_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef FETCH_CNT_EN
        return 32'(n);
`else
        return 32'h0;
`endif
    endfunction

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] sel, input logic taken, input logic [15:0] imm,
                          input logic [25:0] a26, input logic [31:0] jr);
        fif.npc_sel      = sel;
        fif.branch_taken = taken;
        fif.imm16        = imm;
        fif.address26    = a26;
        fif.jr_target    = jr;
    endtask

    // Asynchronous reset pulse placed between edges, then BOOT and first RUN edge
    task automatic reset_and_boot();
        #2 rst_n = 1'b0;
        #2;
        check_val("rst_halt", {31'b0, fif.halt}, 32'h0);
        check_val("rst_fault_pc", fif.fault_pc, 32'h0);
        check_val("rst_cnt", fif.instr_count, 32'h0);
        check_val("rst_pc", fif.pc, 32'h3000);
        check_val("rst_fv", {31'b0, fif.fetch_valid}, 32'h0);
        #1 rst_n = 1'b1;
        step();
        exp_cnt = 0;
        check_val("boot_exit_pc", fif.addr_im, 32'h3000);
        check_val("boot_exit_fv", {31'b0, fif.fetch_valid}, 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        fif.stall = 1'b0;
        set_in(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        #22;
        check_val("reset_pc", fif.pc, 32'h3000);
        check_val("reset_fv", {31'b0, fif.fetch_valid}, 32'h0);
        check_val("reset_cnt", fif.instr_count, 32'h0);
        rst_n = 1'b1;
        #1;
        check_val("boot_addr", fif.addr_im, 32'h3000);
        check_val("boot_fv", {31'b0, fif.fetch_valid}, 32'h0);

        // Sequential: 0x3000 (first valid), 0x3004, 0x3008, 0x300C
        step();
        check_val("seq0_addr", fif.addr_im, 32'h3000);
        check_val("seq0_fv", {31'b0, fif.fetch_valid}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cnt++;
            check_val("seq_addr", fif.addr_im, 32'h3000 + 32'(4 * i));
        end
        check_val("seq_cnt", fif.instr_count, cnt_exp(exp_cnt));
        step(); exp_cnt++;
        check_val("pc_3010", fif.pc, 32'h3010);

        // Taken backward branch from 0x3010
        set_in(2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        step(); exp_cnt++;
        check_val("br_taken", fif.pc, 32'h3004);
        set_in(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        repeat (3) begin step(); exp_cnt++; end
        check_val("pc_3010b", fif.pc, 32'h3010);
        set_in(2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        step(); exp_cnt++;
        check_val("br_not_taken", fif.pc, 32'h3014);

        // Jump from 0x3020
        set_in(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        repeat (3) begin step(); exp_cnt++; end
        check_val("pc_3020", fif.pc, 32'h3020);
        check_val("jal_link", fif.pc_plus8, 32'h3028);
        set_in(2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        step(); exp_cnt++;
        check_val("jump", fif.pc, 32'h3040);

        // Stall at 0x3008 with a pending jr
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h3008);
        step(); exp_cnt++;
        check_val("jr_3008", fif.pc, 32'h3008);
        fif.stall = 1'b1;
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h3100);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_pc", fif.pc, 32'h3008);
        end
        check_val("stall_cnt", fif.instr_count, cnt_exp(exp_cnt));
        fif.stall = 1'b0;
        step(); exp_cnt++;
        check_val("stall_release", fif.pc, 32'h3100);

        // Misaligned jr from 0x3000; stalled first so no fault is recorded yet
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h3000);
        step(); exp_cnt++;
        check_val("jr_3000", fif.pc, 32'h3000);
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h3102);
        fif.stall = 1'b1;
        step();
        check_val("stall_beats_fault", {31'b0, fif.halt}, 32'h0);
        fif.stall = 1'b0;
        step();
        check_val("mis_halt", {31'b0, fif.halt}, 32'h1);
        check_val("mis_fault_pc", fif.fault_pc, 32'h3102);
        check_val("mis_pc", fif.pc, 32'h3000);
        check_val("mis_fv", {31'b0, fif.fetch_valid}, 32'h0);
        check_val("mis_cnt", fif.instr_count, cnt_exp(exp_cnt));
        set_in(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        check_val("halt_sticky", {31'b0, fif.halt}, 32'h1);
        check_val("halt_pc_frozen", fif.pc, 32'h3000);

        // Reset in HALT, then jr past the top of IM
        reset_and_boot();
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h7000);
        step();
        check_val("hi_halt", {31'b0, fif.halt}, 32'h1);
        check_val("hi_fault_pc", fif.fault_pc, 32'h7000);

        // jr below IM base
        reset_and_boot();
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h2FFC);
        step();
        check_val("lo_halt", {31'b0, fif.halt}, 32'h1);
        check_val("lo_fault_pc", fif.fault_pc, 32'h2FFC);

        // Last IM word is legal; sequential fall-off faults
        reset_and_boot();
        set_in(2'd3, 1'b0, 16'h0, 26'h0, 32'h6FFC);
        step(); exp_cnt++;
        check_val("last_word_pc", fif.pc, 32'h6FFC);
        check_val("last_word_halt", {31'b0, fif.halt}, 32'h0);
        set_in(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        check_val("falloff_halt", {31'b0, fif.halt}, 32'h1);
        check_val("falloff_fault_pc", fif.fault_pc, 32'h7000);
        check_val("falloff_pc", fif.pc, 32'h6FFC);
        check_val("falloff_cnt", fif.instr_count, cnt_exp(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
